alu32_status_stage: RTL and testbench

Output stage directly downstream of the 32-bit ALU and its flag calculator. It registers the ALU result and the C/N/Z/V flags behind a valid/ready handshake and maintains an architectural NZCV status register with a sticky overflow bit. It also evaluates a 4-bit condition code against the committed flags, so the sequencer can make branch and predication decisions.

---
 rtl/alu32_status_stage.sv | 87 ++++++++
 tb/tb_alu32_status_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu32_status_stage.sv
// rtl/alu32_status_stage.sv - registered ALU result/flags stage with NZCV status, sticky overflow and condition evaluation
module alu32_status_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_result,
  input  logic        in_c,
  input  logic        in_n,
  input  logic        in_z,
  input  logic        in_v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  nzcv,
  output logic        ovf_sticky,
  input  logic        clr_sticky,
  input  logic [3:0]  cond,
  output logic        cond_true
);

  logic accept;
  logic arith_op;
  logic flag_n, flag_z, flag_c, flag_v;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign arith_op = (in_op[2:1] == 2'b11);
  assign nzcv     = {flag_n, flag_z, flag_c, flag_v};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept) begin
        out_result <= in_result;
        out_valid  <= 1'b1;
        flag_n     <= in_n;
        flag_z     <= in_z;
        // Only add/sub produce meaningful carry and overflow; logic/shift ops keep them.
        if (arith_op) begin
          flag_c <= in_c;
          flag_v <= in_v;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && arith_op && in_v) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = flag_z;
      4'h1: cond_true = !flag_z;
      4'h2: cond_true = flag_c;
      4'h3: cond_true = !flag_c;
      4'h4: cond_true = flag_n;
      4'h5: cond_true = !flag_n;
      4'h6: cond_true = flag_v;
      4'h7: cond_true = !flag_v;
      4'h8: cond_true = flag_c && !flag_z;
      4'h9: cond_true = !flag_c || flag_z;
      4'hA: cond_true = (flag_n == flag_v);
      4'hB: cond_true = (flag_n != flag_v);
      4'hC: cond_true = !flag_z && (flag_n == flag_v);
      4'hD: cond_true = flag_z || (flag_n != flag_v);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu32_status_stage.sv
// tb/tb_alu32_status_stage.sv - directed and randomized checks of alu32_status_stage against a reference model
module tb_alu32_status_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_result;
  logic        in_c, in_n, in_z, in_v;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  nzcv;
  logic        ovf_sticky;
  logic        clr_sticky;
  logic [3:0]  cond;
  logic        cond_true;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_valid;
  logic [31:0] m_result;
  logic [3:0]  m_nzcv;
  logic        m_sticky;

  always #5 clk = ~clk;

  alu32_status_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_result(in_result),
    .in_c(in_c), .in_n(in_n), .in_z(in_z), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .nzcv(nzcv), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .cond(cond), .cond_true(cond_true)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Even codes are a base predicate, odd codes its complement; code 7 base is "always".
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (c[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc & ~fz;
      3'd5: base = (fn == fv);
      3'd6: base = ~fz & (fn == fv);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic step(input logic rst, input logic iv, input logic [2:0] op, input logic [31:0] res,
                      input logic c, input logic n, input logic z, input logic v,
                      input logic ordy, input logic clr, input logic [3:0] cnd);
    logic acc;
    @(negedge clk);
    reset = rst; in_valid = iv; in_op = op; in_result = res;
    in_c = c; in_n = n; in_z = z; in_v = v;
    out_ready = ordy; clr_sticky = clr; cond = cnd;
    #1;
    check("in_ready", in_ready, !m_valid || ordy);
    check("out_valid", out_valid, m_valid);
    check("out_result", out_result, m_result);
    check("nzcv", nzcv, m_nzcv);
    check("ovf_sticky", ovf_sticky, m_sticky);
    check("cond_true", cond_true, cond_model(cnd, m_nzcv));
    acc = !rst && iv && (!m_valid || ordy);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_result = 0; m_nzcv = 0; m_sticky = 0;
    end else begin
      if (acc) begin
        m_valid = 1;
        m_result = res;
        if (op == 3'b110 || op == 3'b111) m_nzcv = {n, z, c, v};
        else m_nzcv = {n, z, m_nzcv[1:0]};
      end else if (ordy) begin
        m_valid = 0;
      end
      if (acc && (op == 3'b110 || op == 3'b111) && v) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
  endtask

  initial begin
    m_valid = 0; m_result = 0; m_nzcv = 0; m_sticky = 0;
    reset = 1; in_valid = 0; in_op = 0; in_result = 0;
    in_c = 0; in_n = 0; in_z = 0; in_v = 0;
    out_ready = 0; clr_sticky = 0; cond = 0;
    @(posedge clk);
    @(posedge clk);
    step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_nzcv", nzcv, 4'b0000);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_in_ready", in_ready, 1);

    // add producing zero with carry
    step(0, 1, 3'b110, 32'd0, 1, 0, 1, 0, 1, 0, 4'h0);
    #1;
    check("tp1_out_valid", out_valid, 1);
    check("tp1_nzcv", nzcv, 4'b0110);
    check("tp1_eq", cond_true, 1);
    cond = 4'h8;
    #1;
    check("tp1_hi", cond_true, 0);

    // sub with overflow, then an AND that must preserve C/V
    step(0, 1, 3'b111, 32'h8000_0000, 0, 1, 0, 1, 1, 0, 4'h6);
    #1;
    check("tp2_nzcv_sub", nzcv, 4'b1001);
    check("tp2_sticky_sub", ovf_sticky, 1);
    step(0, 1, 3'b000, 32'd1, 0, 0, 0, 0, 1, 0, 4'hB);
    #1;
    check("tp2_nzcv_and", nzcv, 4'b0001);
    check("tp2_sticky_and", ovf_sticky, 1);

    // stall with a pending input, then release
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'b110, 32'h1234, 0, 0, 0, 0, 0, 0, 4'hA);
      #1;
      check("tp3_stall_result", out_result, 32'd1);
      check("tp3_stall_nzcv", nzcv, 4'b0001);
    end
    step(0, 1, 3'b110, 32'h1234, 0, 0, 0, 0, 1, 0, 4'hA);
    #1;
    check("tp3_release_result", out_result, 32'h1234);

    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'b010, 32'd100 + i, 0, 0, 0, 0, 1, 0, 4'hE);
      #1;
      check("tp4_stream_valid", out_valid, 1);
      check("tp4_stream_result", out_result, 32'd100 + i);
    end

    // sticky set beats clear, then clear alone
    step(0, 1, 3'b110, 32'd5, 0, 0, 0, 1, 1, 1, 4'h7);
    #1;
    check("tp5_set_wins", ovf_sticky, 1);
    step(0, 0, 3'b110, 32'd0, 0, 0, 0, 1, 1, 1, 4'h7);
    #1;
    check("tp5_clear", ovf_sticky, 0);

    // reset while a result is held under stall
    step(0, 1, 3'b111, 32'hdead_beef, 1, 1, 0, 1, 0, 0, 4'h3);
    step(0, 1, 3'b111, 32'h1, 0, 0, 0, 0, 0, 0, 4'h3);
    step(1, 1, 3'b111, 32'h2, 1, 1, 1, 1, 0, 0, 4'h3);
    #1;
    check("tp6_out_valid", out_valid, 0);
    check("tp6_nzcv", nzcv, 4'b0000);
    check("tp6_sticky", ovf_sticky, 0);
    check("tp6_in_ready", in_ready, 1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 3'($urandom), $urandom,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, 4'($urandom));
    end
    step(0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
